// File: rtl/deco_pkg.sv
// Shared encodings and decode helpers for the deco_scan block.
package deco_pkg;

    // Encoding of the two-bit mode input
    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_DIRECT = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_SWEEP  = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        S_OFF    = 2'b00,
        S_DIRECT = 2'b01,
        S_SCAN   = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    // One bit of a one-hot decode: true when position pos is selected and
    // exists in an out_w-wide vector.
    function automatic logic onehot_bit(input int unsigned sel,
                                        input int unsigned pos,
                                        input int unsigned out_w);
        return (pos < out_w) && (sel == pos);
    endfunction

    // A select value with no matching output line
    function automatic logic out_of_range(input int unsigned sel,
                                          input int unsigned out_w);
        return sel >= out_w;
    endfunction

endpackage

// File: rtl/deco_onehot.sv
// Combinational binary-to-one-hot decoder with an out-of-range flag.
// Positive polarity; any output inversion is done by the caller.
module deco_onehot
    import deco_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot,
    output logic             oor
);

    // One comparator per output line
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
        assign onehot[gi] = onehot_bit(32'(sel), gi, OUT_W);
    end

    assign oor = out_of_range(32'(sel), OUT_W);

endmodule

// File: rtl/deco_scan.sv
// Registered one-hot decoder: handshaked direct decode, or an autonomous
// walking-one scan (continuous or single sweep) with programmable dwell.
module deco_scan
    import deco_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int OUT_W      = 8,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   d,
    output logic               d_valid,
    output logic               err,
    output logic               wrap,
    output logic               done
);

    // Value of d with no line asserted, in output polarity
    localparam logic [OUT_W-1:0] D_IDLE  = {OUT_W{ACTIVE_LOW}};
    localparam logic [SEL_W-1:0] IDX_TOP = SEL_W'(OUT_W - 1);

    state_t             state_reg, state_next;
    logic [1:0]         mode_reg;
    logic [SEL_W-1:0]   index_reg, index_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic [OUT_W-1:0]   d_reg;
    logic [OUT_W-1:0]   dpos_next;
    logic               d_valid_reg, d_valid_next;
    logic               err_reg, err_next;
    logic               wrap_reg, wrap_next;
    logic               done_reg, done_next;

    logic               mode_change;
    logic               last_idx;
    logic               step_end;
    logic               accept;
    state_t             mode_state;
    logic [SEL_W-1:0]   scan_sel;
    logic [SEL_W-1:0]   dec_sel;
    logic [OUT_W-1:0]   dec_onehot;
    logic               dec_oor;

    assign in_ready    = en && (state_reg == S_DIRECT);
    assign accept      = in_valid && in_ready;
    assign mode_change = (mode != mode_reg);
    assign last_idx    = (index_reg == IDX_TOP);
    assign step_end    = (cnt_reg == dwell_reg);

    // Index the scan will display after this edge. The first scan cycle
    // (d not yet valid) shows index 0, which is where entry left index_reg.
    assign scan_sel = (d_valid_reg && !last_idx) ? index_reg + SEL_W'(1) : '0;
    assign dec_sel  = (state_reg == S_DIRECT) ? in : scan_sel;

    deco_onehot #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_onehot (
        .sel    (dec_sel),
        .onehot (dec_onehot),
        .oor    (dec_oor)
    );

    // State the current mode input asks for; a held SWEEP keeps S_DONE
    always_comb begin
        mode_state = S_OFF;
        case (mode)
            MODE_OFF:    mode_state = S_OFF;
            MODE_DIRECT: mode_state = S_DIRECT;
            default:     mode_state = (state_reg == S_DONE && mode == MODE_SWEEP)
                                      ? S_DONE : S_SCAN;
        endcase
    end

    // Next-state, counter and output-register logic
    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        cnt_next     = cnt_reg;
        dwell_next   = dwell_reg;
        dpos_next    = d_reg ^ D_IDLE;
        d_valid_next = d_valid_reg;
        err_next     = 1'b0;
        wrap_next    = 1'b0;
        done_next    = done_reg;

        if (mode_change) begin
            // Any mode change restarts from a clean, deasserted output.
            // An input accepted on this same edge is dropped.
            state_next   = mode_state;
            index_next   = '0;
            cnt_next     = '0;
            dpos_next    = '0;
            d_valid_next = 1'b0;
            done_next    = 1'b0;
        end else begin
            case (state_reg)
                S_OFF: begin
                    dpos_next    = '0;
                    d_valid_next = 1'b0;
                end
                S_DIRECT: begin
                    if (accept) begin
                        if (dec_oor) begin
                            dpos_next    = '0;
                            d_valid_next = 1'b0;
                            err_next     = 1'b1;
                        end else begin
                            dpos_next    = dec_onehot;
                            d_valid_next = 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (!d_valid_reg) begin
                        // First scan cycle: show index 0, start its step
                        dpos_next    = dec_onehot;
                        d_valid_next = 1'b1;
                        cnt_next     = '0;
                        dwell_next   = dwell;
                    end else if (step_end) begin
                        cnt_next   = '0;
                        dwell_next = dwell;
                        if (last_idx && mode == MODE_SWEEP) begin
                            state_next   = S_DONE;
                            index_next   = '0;
                            dpos_next    = '0;
                            d_valid_next = 1'b0;
                            done_next    = 1'b1;
                        end else begin
                            index_next = scan_sel;
                            dpos_next  = dec_onehot;
                            wrap_next  = last_idx;
                        end
                    end else begin
                        cnt_next = cnt_reg + DWELL_W'(1);
                    end
                end
                S_DONE: begin
                    dpos_next    = '0;
                    d_valid_next = 1'b0;
                end
                default: begin
                    state_next = S_OFF;
                end
            endcase
        end
    end

    // State and output registers; en low freezes everything except the
    // pulses, which drop so each lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_OFF;
            mode_reg    <= MODE_OFF;
            index_reg   <= '0;
            cnt_reg     <= '0;
            dwell_reg   <= '0;
            d_reg       <= D_IDLE;
            d_valid_reg <= 1'b0;
            err_reg     <= 1'b0;
            wrap_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else if (en) begin
            state_reg   <= state_next;
            mode_reg    <= mode;
            index_reg   <= index_next;
            cnt_reg     <= cnt_next;
            dwell_reg   <= dwell_next;
            d_reg       <= dpos_next ^ D_IDLE;
            d_valid_reg <= d_valid_next;
            err_reg     <= err_next;
            wrap_reg    <= wrap_next;
            done_reg    <= done_next;
        end else begin
            err_reg     <= 1'b0;
            wrap_reg    <= 1'b0;
        end
    end

    assign d       = d_reg;
    assign d_valid = d_valid_reg;
    assign err     = err_reg;
    assign wrap    = wrap_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_deco_scan.sv
// Directed bench for deco_scan: default 8-line, 6-line and active-low
// instances share one stimulus stream.
module tb_deco_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [2:0] in;
    logic       in_valid;
    logic [7:0] dwell;

    logic [7:0] d8;  logic dv8, rdy8, err8, wrap8, done8;
    logic [5:0] d6;  logic dv6, rdy6, err6, wrap6, done6;
    logic [7:0] dl;  logic dvl, rdyl, errl, wrapl, donel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    deco_scan u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
        .in_valid(in_valid), .in_ready(rdy8), .dwell(dwell), .d(d8),
        .d_valid(dv8), .err(err8), .wrap(wrap8), .done(done8)
    );

    deco_scan #(.OUT_W(6)) u6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
        .in_valid(in_valid), .in_ready(rdy6), .dwell(dwell), .d(d6),
        .d_valid(dv6), .err(err6), .wrap(wrap6), .done(done6)
    );

    deco_scan #(.ACTIVE_LOW(1'b1)) ul (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
        .in_valid(in_valid), .in_ready(rdyl), .dwell(dwell), .d(dl),
        .d_valid(dvl), .err(errl), .wrap(wrapl), .done(donel)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'b00; in = 3'd0; in_valid = 1'b0; dwell = 8'd0;
        step(2);
        check("rst_d8",    32'(d8),    32'h00);
        check("rst_dv8",   32'(dv8),   32'h0);
        check("rst_err8",  32'(err8),  32'h0);
        check("rst_wrap8", 32'(wrap8), 32'h0);
        check("rst_done8", 32'(done8), 32'h0);
        check("rst_rdy8",  32'(rdy8),  32'h0);
        check("rst_dl",    32'(dl),    32'hFF);
        rst_n = 1'b1;
        step(1);

        // DIRECT decode with one-cycle latency, then hold
        mode = 2'b01;
        step(1);
        check("dir_rdy8", 32'(rdy8), 32'h1);
        en = 1'b0; #1;
        check("dir_rdy8_en0", 32'(rdy8), 32'h0);
        en = 1'b1;
        in = 3'd5; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check("dir_d8_5",  32'(d8),  32'h20);
        check("dir_dv8",   32'(dv8), 32'h1);
        check("dir_d6_5",  32'(d6),  32'h20);
        check("dir_dl_5",  32'(dl),  32'hDF);
        step(10);
        check("dir_hold_d8",  32'(d8),  32'h20);
        check("dir_hold_dv8", 32'(dv8), 32'h1);

        // Range error on the 6-line instance; the 8-line one accepts 7
        in = 3'd7; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check("oor_d6",   32'(d6),   32'h00);
        check("oor_dv6",  32'(dv6),  32'h0);
        check("oor_err6", 32'(err6), 32'h1);
        check("oor_err8", 32'(err8), 32'h0);
        check("oor_d8_7", 32'(d8),   32'h80);
        step(1);
        check("oor_err6_drop", 32'(err6), 32'h0);
        in = 3'd5; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check("oor_d6_5",  32'(d6),  32'h20);
        check("oor_dv6_5", 32'(dv6), 32'h1);

        // Active-low output
        in = 3'd0; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        check("al_dl_0",  32'(dl),  32'hFE);
        check("al_dvl_0", 32'(dvl), 32'h1);

        // Continuous scan, dwell 2: entry edge deasserts, then 3 cycles per line
        dwell = 8'd2; mode = 2'b10;
        in = 3'd7; in_valid = 1'b1;       // ignored outside DIRECT
        step(1);
        check("scan_entry_d8",  32'(d8),  32'h00);
        check("scan_entry_dv8", 32'(dv8), 32'h0);
        check("scan_rdy8",      32'(rdy8), 32'h0);
        for (int k = 0; k < 24; k++) begin
            step(1);
            check($sformatf("scan_d8_%0d", k), 32'(d8), 32'(1 << (k / 3)));
            check($sformatf("scan_wrap8_%0d", k), 32'(wrap8), 32'h0);
        end
        check("scan_err6_ignored", 32'(err6), 32'h0);
        step(1);
        check("scan_wrap_d8",  32'(d8),    32'h01);
        check("scan_wrap8",    32'(wrap8), 32'h1);
        step(1);
        check("scan_wrap8_drop", 32'(wrap8), 32'h0);
        in_valid = 1'b0;

        // Asynchronous reset mid-scan, before the next edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_d8",    32'(d8),    32'h00);
        check("arst_dv8",   32'(dv8),   32'h0);
        check("arst_wrap8", 32'(wrap8), 32'h0);
        check("arst_err8",  32'(err8),  32'h0);
        check("arst_done8", 32'(done8), 32'h0);
        check("arst_dl",    32'(dl),    32'hFF);
        mode = 2'b00;
        step(1);
        rst_n = 1'b1;
        step(1);

        // Single sweep, dwell 0, with en low for three cycles at line 2
        dwell = 8'd0; mode = 2'b11;
        step(1);
        check("swp_entry_d8", 32'(d8), 32'h00);
        step(3);
        check("swp_d8_04", 32'(d8), 32'h04);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check($sformatf("swp_freeze_d8_%0d", k), 32'(d8), 32'h04);
        end
        en = 1'b1;
        for (int k = 3; k < 8; k++) begin
            step(1);
            check($sformatf("swp_d8_%0d", k), 32'(d8), 32'(1 << k));
        end
        step(1);
        check("swp_done8",   32'(done8), 32'h1);
        check("swp_end_d8",  32'(d8),    32'h00);
        check("swp_end_dv8", 32'(dv8),   32'h0);
        check("swp_wrap8",   32'(wrap8), 32'h0);
        step(5);
        check("swp_done8_held", 32'(done8), 32'h1);
        check("swp_d8_held",    32'(d8),    32'h00);
        mode = 2'b00;
        step(1);
        check("swp_done8_clear", 32'(done8), 32'h0);

        // Re-arm the sweep via OFF
        mode = 2'b11;
        step(2);
        check("rearm_d8", 32'(d8), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/deco_scan.md
Name: deco_scan

Overview:
- Parametrised, registered successor to the team's combinational 3-to-8 decoder.
- Converts a binary select into a one-hot output vector in one of two ways:
  - direct, handshaked decode;
  - autonomous walking-one scan with programmable dwell, either continuous or single sweep.
- Used to drive row/channel enables, LED/segment strobes and bus-select lines from a single clocked block.

Parameters:
- SEL_W, 3, width of binary select input.
- OUT_W, 8, number of one-hot outputs; legal range 2..2**SEL_W.
- DWELL_W, 8, width of the dwell-count input.
- ACTIVE_LOW, 0, 1 inverts every bit of d (asserted output = 0).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  clock enable; 0 freezes all state and outputs.
- mode  input  2  00 OFF, 01 DIRECT, 10 SCAN (continuous), 11 SWEEP (one pass).
- in  input  SEL_W  binary select, DIRECT mode only.
- in_valid  input  1  in is valid.
- in_ready  output  1  block accepts in this cycle.
- dwell  input  DWELL_W  cycles per scan step minus one.
- d  output  OUT_W  registered one-hot (or zero) decode.
- d_valid  output  1  d holds an asserted line.
- err  output  1  one-cycle pulse: accepted in >= OUT_W.
- wrap  output  1  one-cycle pulse: scan left index OUT_W-1.
- done  output  1  level: SWEEP finished; cleared on leaving SWEEP.

Behaviour:
- Reset (async assert, sync release):
  - state = S_OFF, index = 0, dwell counter = 0.
  - d = all-deasserted: 0, or all ones when ACTIVE_LOW = 1.
  - d_valid, err, wrap, done, in_ready = 0.
- All outputs are registered, except in_ready, which is combinational from state and en.
- en = 0: no state, counter or output changes; in_ready = 0; pulses do not repeat.
- States: S_OFF, S_DIRECT, S_SCAN, S_DONE. mode is sampled every enabled cycle:
  - 00 -> S_OFF
  - 01 -> S_DIRECT
  - 10 or 11 -> S_SCAN, unless already in S_DONE with mode = 11.
- Any mode change:
  - takes effect on the next enabled edge;
  - clears index and dwell counter;
  - deasserts d on that same edge.
  - A scan entered from another mode therefore shows index 0 one cycle later.
- S_OFF: d deasserted, d_valid = 0.
- S_DIRECT:
  - in_ready = en.
  - On in_valid & in_ready: the next edge loads d = onehot(in), d_valid = 1. Latency 1 cycle.
  - d holds until the next accepted in or a mode change.
  - in >= OUT_W (possible only when OUT_W < 2**SEL_W): d deasserted, d_valid = 0, err = 1 for one cycle.
- S_SCAN:
  - d = onehot(index), d_valid = 1.
  - The dwell counter counts 0..dwell. At dwell it resets and index advances.
  - dwell is sampled at each step start; a change mid-step applies from the next step.
  - dwell = 0 advances every cycle.
  - Advancing from OUT_W-1: index -> 0 and wrap = 1 on the same edge.
  - mode = 11: advancing from OUT_W-1 instead goes to S_DONE; d deasserted, d_valid = 0, done = 1.
  - Continuous mode cycle length = OUT_W*(dwell+1).
- S_DONE:
  - Outputs stay deasserted; done held.
  - mode = 11 held: stay.
  - Any other mode: leave, done -> 0.
  - Re-arm a sweep via 00/01 then 11.
- in_valid outside S_DIRECT is ignored; no err.
- Reset mid-scan or mid-transfer: immediate return to reset values; nothing is resumed.

Decomposition:
- Package deco_pkg:
  - mode encodings MODE_OFF/DIRECT/SCAN/SWEEP;
  - state encodings S_OFF/S_DIRECT/S_SCAN/S_DONE;
  - onehot function parametrised by OUT_W.
- One sub-module, deco_onehot: purely combinational SEL_W -> OUT_W decode with an out-of-range flag, shared by the DIRECT and SCAN paths.
- Polarity inversion is applied once at the output register.

Test Plan:
- Reset: rst_n = 0 mid-scan with ACTIVE_LOW = 0 -> d = 8'h00, d_valid = 0, all pulses 0, asynchronously, before the next clk edge.
- DIRECT: mode = 01, in = 3'b101, in_valid = 1 for one cycle -> next cycle d = 8'b0010_0000, d_valid = 1; held 10 cycles with in_valid = 0.
- Range error: OUT_W = 6, mode = 01, in = 3'd7 -> d = 0, d_valid = 0, err high exactly 1 cycle; then in = 3'd5 -> d = 6'b10_0000.
- SCAN: mode = 10, dwell = 2 -> d steps 8'h01, 8'h02 ... 8'h80, 3 cycles each; wrap pulses on the 24-cycle boundary as d returns to 8'h01.
- SWEEP + en: mode = 11, dwell = 0, en low for cycles 3-5 -> d freezes at 8'h04 for 3 cycles; sweep ends with d = 0, done = 1, held until mode = 00.
- ACTIVE_LOW = 1: mode = 01, in = 3'd0 -> d = 8'hFE; reset -> d = 8'hFF.
